aes_round_ctrl: RTL

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl_pkg.sv | 63 ++++++
 rtl/add_round_key.sv | 12 +
 rtl/aes_key_step.sv | 26 ++
 rtl/mix_columns.sv | 30 +++
 rtl/shift_rows.sv | 23 ++
 rtl/sub_bytes.sv | 20 ++
 rtl/aes_round_ctrl.sv | 104 ++++++++++
 7 files changed

// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES-128 definitions: FSM encoding, round count, rcon table and GF(2^8) helpers.
package aes_round_ctrl_pkg;

   localparam int unsigned AES_ROUNDS = 10;
   localparam int unsigned BLOCK_W    = 128;
   localparam int unsigned ROUND_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [7:0] RCON [AES_ROUNDS] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // rcon byte for rounds 1..10; zero elsewhere
   function automatic logic [7:0] rcon_for(input logic [ROUND_W-1:0] round);
      logic [7:0] r;
      r = 8'h00;
      for (int unsigned i = 0; i < AES_ROUNDS; i++) begin
         if (32'(round) == i + 1) r = RCON[4'(i)];
      end
      return r;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (a^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] inv;
      p   = a;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p   = gf_mul(p, p);
         inv = gf_mul(inv, p);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Byte n of a block (byte 0 in the top bits, column-major state order)
   function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk, input int unsigned n);
      return blk[7'(BLOCK_W - 8 - 8 * n) +: 8];
   endfunction

endpackage

// File: rtl/add_round_key.sv
// XOR of the state with the round key.
module add_round_key
   import aes_round_ctrl_pkg::*;
(
   input  logic [BLOCK_W-1:0] data,
   input  logic [BLOCK_W-1:0] round_key,
   output logic [BLOCK_W-1:0] result
);

   assign result = data ^ round_key;

endmodule

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: RotWord, SubWord, rcon XOR and word chaining.
module aes_key_step
   import aes_round_ctrl_pkg::*;
(
   input  logic [BLOCK_W-1:0] key,
   input  logic [7:0]         rcon,
   output logic [BLOCK_W-1:0] next_key
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot, temp;
   logic [31:0] n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = key;
   assign rot  = {w3[23:0], w3[31:24]};
   assign temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                 ^ {rcon, 24'h000000};

   assign n0 = w0 ^ temp;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/mix_columns.sv
// Per-column multiply by the fixed polynomial {03}x^3+{01}x^2+{01}x+{02}.
module mix_columns
   import aes_round_ctrl_pkg::*;
(
   input  logic [BLOCK_W-1:0] data,
   output logic [BLOCK_W-1:0] result
);

   function automatic logic [BLOCK_W-1:0] mix_f(input logic [BLOCK_W-1:0] d);
      logic [BLOCK_W-1:0] r;
      logic [7:0] a0, a1, a2, a3;
      r = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = get_byte(d, 4 * c);
         a1 = get_byte(d, 4 * c + 1);
         a2 = get_byte(d, 4 * c + 2);
         a3 = get_byte(d, 4 * c + 3);
         r[BLOCK_W - 1 - 32 * c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
         };
      end
      return r;
   endfunction

   assign result = mix_f(data);

endmodule

// File: rtl/shift_rows.sv
// Cyclic left rotation of row r by r byte positions.
module shift_rows
   import aes_round_ctrl_pkg::*;
(
   input  logic [BLOCK_W-1:0] data,
   output logic [BLOCK_W-1:0] result
);

   function automatic logic [BLOCK_W-1:0] shift_f(input logic [BLOCK_W-1:0] d);
      logic [BLOCK_W-1:0] r;
      r = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned row = 0; row < 4; row++) begin
            r[7'(BLOCK_W - 8 - 8 * (row + 4 * c)) +: 8] =
               get_byte(d, row + 4 * ((c + row) % 4));
         end
      end
      return r;
   endfunction

   assign result = shift_f(data);

endmodule

// File: rtl/sub_bytes.sv
// Byte-wise S-box substitution over the whole state.
module sub_bytes
   import aes_round_ctrl_pkg::*;
(
   input  logic [BLOCK_W-1:0] data,
   output logic [BLOCK_W-1:0] result
);

   function automatic logic [BLOCK_W-1:0] sub_f(input logic [BLOCK_W-1:0] d);
      logic [BLOCK_W-1:0] r;
      r = '0;
      for (int unsigned n = 0; n < 16; n++) begin
         r[7'(BLOCK_W - 8 - 8 * n) +: 8] = sbox(get_byte(d, n));
      end
      return r;
   endfunction

   assign result = sub_f(data);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, valid/ready on both sides.
module aes_round_ctrl
   import aes_round_ctrl_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [BLOCK_W-1:0] i_plaintext,
   input  logic [BLOCK_W-1:0] i_key,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [BLOCK_W-1:0] o_ciphertext,
   output logic               o_busy,
   output logic [ROUND_W-1:0] o_round
);

   state_e             state_q, state_next;
   logic [ROUND_W-1:0] round_q, round_next;
   logic [BLOCK_W-1:0] state_reg, state_reg_next;
   logic [BLOCK_W-1:0] key_reg, key_reg_next;

   logic [BLOCK_W-1:0] next_key;
   logic [BLOCK_W-1:0] subbed, shifted, mixed, mix_sel, round_out;
   logic               last_round;

   aes_key_step u_key_step (
      .key      (key_reg),
      .rcon     (rcon_for(round_q)),
      .next_key (next_key)
   );

   sub_bytes   u_sub_bytes   (.data(state_reg), .result(subbed));
   shift_rows  u_shift_rows  (.data(subbed),    .result(shifted));
   mix_columns u_mix_columns (.data(shifted),   .result(mixed));

   // Final round skips MixColumns
   assign last_round = (round_q == ROUND_W'(AES_ROUNDS));
   assign mix_sel    = last_round ? shifted : mixed;

   add_round_key u_add_round_key (
      .data      (mix_sel),
      .round_key (next_key),
      .result    (round_out)
   );

   always_comb begin
      state_next     = state_q;
      round_next     = round_q;
      state_reg_next = state_reg;
      key_reg_next   = key_reg;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               state_reg_next = i_plaintext ^ i_key;
               key_reg_next   = i_key;
               round_next     = ROUND_W'(1);
               state_next     = ST_BUSY;
            end
         end
         ST_BUSY: begin
            state_reg_next = round_out;
            key_reg_next   = next_key;
            if (last_round) state_next = ST_DONE;
            else            round_next = round_q + ROUND_W'(1);
         end
         ST_DONE: begin
            // Handoff edge only returns to IDLE; no same-edge re-accept
            if (i_ready) begin
               state_next = ST_IDLE;
               round_next = '0;
            end
         end
         default: begin
            state_next = ST_IDLE;
            round_next = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         round_q   <= '0;
         state_reg <= '0;
         key_reg   <= '0;
         o_ready   <= 1'b1;
         o_busy    <= 1'b0;
         o_valid   <= 1'b0;
      end else begin
         state_q   <= state_next;
         round_q   <= round_next;
         state_reg <= state_reg_next;
         key_reg   <= key_reg_next;
         o_ready   <= (state_next == ST_IDLE);
         o_busy    <= (state_next == ST_BUSY);
         o_valid   <= (state_next == ST_DONE);
      end
   end

   assign o_ciphertext = state_reg;
   assign o_round      = round_q;

endmodule
